// File: rtl/processor_pkg.sv
// processor_pkg: shared widths, FSM states and grant encoding for the memory initiator.
package processor_pkg;
  localparam int DW = 18;
  localparam int AW = 13;
  localparam int DEPTH = 128;
  localparam int BOOT_WAIT = 2;
  localparam int CW = $clog2(BOOT_WAIT + 1);
  typedef enum logic [2:0] {ST_BOOT, ST_IDLE, ST_RD, ST_RWAIT, ST_WR, ST_RESP} state_t;
  typedef enum logic {GNT_IF, GNT_D} gnt_t;
  function automatic logic in_range(input logic [AW-1:0] a);
    return a < AW'(DEPTH);
  endfunction
endpackage

// File: rtl/mem_initiator.sv
// mem_initiator: arbitrates fetch and data requests onto one registered-read memory channel.
module mem_initiator
  import processor_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          err,
  output logic          busy,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  state_t        r_state, w_ns;
  gnt_t          r_gnt, w_gnt;
  logic [CW-1:0] r_cnt;
  logic          r_if_wait;
  logic          w_start, w_oor, w_cap;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_rd;
  // data wins unless a fetch already lost the previous contention
  assign w_gnt   = (r_state == ST_IDLE) ? ((d_req && !(if_req && r_if_wait)) ? GNT_D : GNT_IF) : r_gnt;
  assign w_addr  = (w_gnt == GNT_D) ? d_addr : if_addr;
  assign w_start = (r_state == ST_IDLE) && (d_req || if_req);
  assign w_oor   = !in_range(w_addr);
  assign w_cap   = (r_state == ST_RWAIT) || (w_start && w_oor);
  assign w_rd    = (r_state == ST_RWAIT) ? mem_rdata : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ST_BOOT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_ns;
      r_cnt   <= (r_state == ST_BOOT) ? r_cnt + 1'b1 : '0;
    end
  always_comb begin
    w_ns = r_state;
    case (r_state)
      ST_BOOT:  w_ns = (r_cnt == CW'(BOOT_WAIT - 1)) ? ST_IDLE : ST_BOOT;
      ST_IDLE:  w_ns = !w_start ? ST_IDLE : w_oor ? ST_RESP : (w_gnt == GNT_D && d_we) ? ST_WR : ST_RD;
      ST_RD:    w_ns = ST_RWAIT;
      ST_RWAIT: w_ns = ST_RESP;
      ST_WR:    w_ns = ST_RESP;
      default:  w_ns = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_gnt     <= GNT_IF;
      r_if_wait <= 1'b0;
      busy      <= 1'b1;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      err       <= 1'b0;
    end else begin
      busy    <= w_ns != ST_IDLE;
      mem_re  <= w_ns == ST_RD;
      mem_we  <= w_ns == ST_WR;
      if_done <= (w_ns == ST_RESP) && (w_gnt == GNT_IF);
      d_done  <= (w_ns == ST_RESP) && (w_gnt == GNT_D);
      err     <= w_start && w_oor;
      if (w_start) begin
        r_gnt     <= w_gnt;
        r_if_wait <= d_req && if_req && (w_gnt == GNT_D);
        if (!w_oor) mem_addr <= w_addr;
        if (w_ns == ST_WR) mem_wdata <= d_wdata;
      end
      if (w_cap) begin
        if (w_gnt == GNT_D) d_rdata <= w_rd;
        else if_rdata <= w_rd;
      end
    end
  assert property (@(posedge clk) disable iff (rst) !(mem_re && mem_we));
endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: vector table, corner sequences and random traffic against a memory model.
module tb_mem_initiator;
  import processor_pkg::*;
  logic clk = 0, rst = 1;
  logic if_req = 0, d_req = 0, d_we = 0;
  logic [AW-1:0] if_addr = 0, d_addr = 0;
  logic [DW-1:0] d_wdata = 0, mem_rdata = 0;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic if_done, d_done, err, busy, mem_re, mem_we;
  logic [AW-1:0] mem_addr;
  always #5 clk = ~clk;

  mem_initiator dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .err(err), .busy(busy), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return i == 0 ? 18'b001010000000010100 : i == 20 ? 18'd42 : i == 21 ? 18'd3 : DW'(i * 1001 + 5);
  endfunction

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic preloaded = 0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
      preloaded <= 1;
    end else if (mem_we && mem_addr < AW'(DEPTH)) mem[mem_addr[6:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[6:0]];
  end

  int n_re = 0, n_we = 0, n_both = 0;
  always @(negedge clk) begin
    if (mem_re) n_re++;
    if (mem_we) n_we++;
    if (mem_re && mem_we) n_both++;
  end

  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] last_d = 0, last_if = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input bit is_d, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int lat, input logic [DW-1:0] rd, input bit e, input string nm);
    int re0, we0, c;
    bit got;
    re0 = n_re; we0 = n_we; c = 0; got = 0;
    if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wd; end
    else begin if_req = 1; if_addr = addr; end
    while (!got && c < 30) begin
      @(negedge clk);
      c++;
      got = is_d ? d_done : if_done;
      if (!got && c == 1 && lat <= 3) begin
        d_addr = AW'($urandom); d_wdata = DW'($urandom); if_addr = AW'($urandom);
        if (!is_d) d_we = 1'($urandom);
      end
    end
    check({nm, " done"}, got, 1);
    check({nm, " latency"}, c, lat);
    check({nm, " rdata"}, is_d ? d_rdata : if_rdata, rd);
    check({nm, " err"}, err, e);
    check({nm, " other_done"}, is_d ? if_done : d_done, 0);
    if (is_d) d_req = 0; else if_req = 0;
    @(negedge clk);
    check({nm, " busy_idle"}, busy, 0);
    check({nm, " re_cycles"}, n_re - re0, (!e && !(is_d && we)) ? 1 : 0);
    check({nm, " we_cycles"}, n_we - we0, (!e && is_d && we) ? 1 : 0);
    if (is_d && we && !e) ref_mem[addr[6:0]] = wd;
    if (is_d) last_d = rd; else last_if = rd;
  endtask

  typedef struct {
    bit is_d; bit we; logic [AW-1:0] addr; logic [DW-1:0] wd; int lat; logic [DW-1:0] rd; bit e;
  } vec_t;
  vec_t vecs [11];

  initial begin
    int c;
    bit is_d, we, e;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    vecs[0]  = '{1, 0, 20,  0,        3, 42,       0};
    vecs[1]  = '{1, 1, 22,  45,       2, 42,       0};
    vecs[2]  = '{1, 0, 22,  0,        3, 45,       0};
    vecs[3]  = '{0, 0, 21,  0,        3, 3,        0};
    vecs[4]  = '{1, 0, 200, 0,        1, 0,        1};
    vecs[5]  = '{0, 0, 128, 0,        1, 0,        1};
    vecs[6]  = '{0, 0, 127, 0,        3, 127132,   0};
    vecs[7]  = '{1, 1, 127, 18'h3FFFF, 2, 0,        0};
    vecs[8]  = '{1, 0, 127, 0,        3, 18'h3FFFF, 0};
    vecs[9]  = '{1, 1, 200, 18'h155,  1, 0,        1};
    vecs[10] = '{0, 0, 0,   0,        3, 40980,    0};

    if_req = 1; if_addr = 0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {if_rdata, d_rdata, if_done, d_done, err, mem_re, mem_we, mem_addr, mem_wdata}, 0);
    check("reset_busy", busy, 1);
    rst = 0;
    run_txn(0, 0, 0, 0, BOOT_WAIT + 3, 18'b001010000000010100, 0, "boot_fetch");

    for (int i = 0; i < 11; i++)
      run_txn(vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].lat, vecs[i].rd, vecs[i].e,
              $sformatf("vec%0d", i));

    if_req = 1; if_addr = 1; d_req = 1; d_we = 0; d_addr = 21;
    c = 0;
    while (!d_done && !if_done && c < 30) begin @(negedge clk); c++; end
    check("cont_d_first", {d_done, if_done}, 2'b10);
    check("cont_d_latency", c, 3);
    check("cont_d_rdata", d_rdata, 3);
    d_req = 0;
    c = 0;
    while (!if_done && c < 30) begin @(negedge clk); c++; end
    check("cont_if_latency", c, 4);
    check("cont_if_rdata", if_rdata, 1006);
    if_req = 0;
    @(negedge clk);
    last_d = 3; last_if = 1006;

    d_req = 1; d_we = 0; d_addr = 20;
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    check("midrst_outputs", {if_rdata, d_rdata, if_done, d_done, err, mem_re, mem_we, mem_addr, mem_wdata}, 0);
    check("midrst_busy", busy, 1);
    @(negedge clk);
    check("midrst_no_done", d_done, 0);
    rst = 0;
    run_txn(1, 0, 20, 0, BOOT_WAIT + 3, 42, 0, "midrst_reissue");
    check("midrst_if_rdata", if_rdata, 0);
    last_if = 0;

    for (int i = 0; i < 300; i++) begin
      is_d = 1'($urandom);
      we = is_d && 1'($urandom);
      a = ($urandom % 8 == 0) ? AW'($urandom_range(DEPTH, 8191)) : AW'($urandom_range(0, DEPTH - 1));
      wd = DW'($urandom);
      e = a >= AW'(DEPTH);
      rd = e ? '0 : we ? last_d : ref_mem[a[6:0]];
      run_txn(is_d, we, a, wd, e ? 1 : we ? 2 : 3, rd, e, $sformatf("rnd%0d", i));
    end

    check("re_we_exclusive", n_both, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
